// File: rtl/mc_controller.sv
// Multicycle MIPS control unit.
// A Moore FSM steps each instruction through fetch, decode, execute, memory and
// writeback on a shared-memory datapath. Memory phases wait for mem_ready.
// Undecodable opcodes raise a one-cycle illegal pulse and return to fetch.
module mc_controller #(
  parameter int ACW        = 4,
  parameter int EN_SUBWORD = 1,
  parameter int EN_LINK    = 1
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [5:0]     op,
  input  logic [5:0]     funct,
  input  logic           zero,
  input  logic           mem_ready,
  output logic           iord,
  output logic           memread,
  output logic           memwrite,
  output logic           irwrite,
  output logic           pcen,
  output logic [1:0]     pcsrc,
  output logic           alusrca,
  output logic [1:0]     alusrcb,
  output logic           zeroimm,
  output logic [ACW-1:0] alucontrol,
  output logic           regdst,
  output logic           memtoreg,
  output logic           regwrite,
  output logic           ne,
  output logic           half,
  output logic           b,
  output logic           lbu,
  output logic           link,
  output logic           illegal
);

  localparam bit SUB_ON  = (EN_SUBWORD != 0);
  localparam bit LINK_ON = (EN_LINK != 0);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SH    = 6'b101001;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BRANCH  = 4'd8,
    S_IEX     = 4'd9,
    S_IWB     = 4'd10,
    S_JUMP    = 4'd11,
    S_JAL     = 4'd12,
    S_JR      = 4'd13
  } state_t;

  state_t     state_reg, state_next, decode_next;
  logic       run_reg;
  logic       pcwrite, branch;
  logic [3:0] alu_op;
  logic       op_legal, op_store, op_half, op_byte, op_ubyte;

  // R-type funct field to ALU operation; unknown functs fall back to ADD
  function automatic logic [3:0] rtype_alu(input logic [5:0] f);
    case (f)
      6'b100000: return ALU_ADD;
      6'b100010: return ALU_SUB;
      6'b100100: return ALU_AND;
      6'b100101: return ALU_OR;
      6'b100111: return ALU_NOR;
      6'b101010: return ALU_SLT;
      default:   return ALU_ADD;
    endcase
  endfunction

  // Immediate-form opcode to ALU operation
  function automatic logic [3:0] imm_alu(input logic [5:0] o);
    case (o)
      OP_ANDI: return ALU_AND;
      OP_ORI:  return ALU_OR;
      OP_SLTI: return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

  assign op_store = (op == OP_SW) || (SUB_ON && ((op == OP_SB) || (op == OP_SH)));
  assign op_half  = (op == OP_LH) || (op == OP_SH);
  assign op_byte  = (op == OP_LB) || (op == OP_SB) || (op == OP_LBU);
  assign op_ubyte = (op == OP_LBU);
  assign op_legal = (decode_next != S_FETCH);

  // run_reg keeps every output quiet until the first clock after reset release
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) run_reg <= 1'b0;
    else          run_reg <= 1'b1;
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= S_FETCH;
    else          state_reg <= state_next;
  end

  // Instruction decode: where DECODE goes; FETCH means the opcode is not supported
  always_comb begin
    decode_next = S_FETCH;
    case (op)
      OP_LW, OP_SW:                   decode_next = S_MEMADR;
      OP_LB, OP_LH, OP_LBU, OP_SB, OP_SH: if (SUB_ON) decode_next = S_MEMADR;
      OP_RTYPE: begin
        if (funct == FN_JR) begin
          if (LINK_ON) decode_next = S_JR;
        end else begin
          decode_next = S_RTYPEEX;
        end
      end
      OP_BEQ, OP_BNE:                 decode_next = S_BRANCH;
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: decode_next = S_IEX;
      OP_J:                           decode_next = S_JUMP;
      OP_JAL:                         if (LINK_ON) decode_next = S_JAL;
      default:                        decode_next = S_FETCH;
    endcase
  end

  // Next-state logic; memory states wait on mem_ready, stray encodings recover to FETCH
  always_comb begin
    state_next = S_FETCH;
    if (run_reg) begin
      case (state_reg)
        S_FETCH:   state_next = mem_ready ? S_DECODE : S_FETCH;
        S_DECODE:  state_next = decode_next;
        S_MEMADR:  state_next = op_store ? S_MEMWR : S_MEMRD;
        S_MEMRD:   state_next = mem_ready ? S_MEMWB : S_MEMRD;
        S_MEMWR:   state_next = mem_ready ? S_FETCH : S_MEMWR;
        S_RTYPEEX: state_next = S_RTYPEWB;
        S_IEX:     state_next = S_IWB;
        default:   state_next = S_FETCH;
      endcase
    end
  end

  // Moore output decode (FETCH handshake strobes follow mem_ready)
  always_comb begin
    iord = 1'b0;  memread = 1'b0;  memwrite = 1'b0;  irwrite = 1'b0;
    pcwrite = 1'b0;  branch = 1'b0;  pcsrc = 2'b00;  alusrca = 1'b0;
    alusrcb = 2'b00;  zeroimm = 1'b0;  alu_op = ALU_AND;  regdst = 1'b0;
    memtoreg = 1'b0;  regwrite = 1'b0;  ne = 1'b0;  half = 1'b0;
    b = 1'b0;  lbu = 1'b0;  link = 1'b0;  illegal = 1'b0;
    if (run_reg) begin
      case (state_reg)
        S_FETCH: begin
          memread = 1'b1;  irwrite = mem_ready;  pcwrite = mem_ready;
          alusrcb = 2'b01;  alu_op = ALU_ADD;
        end
        S_DECODE: begin
          alusrcb = 2'b11;  alu_op = ALU_ADD;  illegal = ~op_legal;
        end
        S_MEMADR: begin
          alusrca = 1'b1;  alusrcb = 2'b10;  alu_op = ALU_ADD;
          half = op_half;  b = op_byte;  lbu = op_ubyte;
        end
        S_MEMRD: begin
          iord = 1'b1;  memread = 1'b1;
          half = op_half;  b = op_byte;  lbu = op_ubyte;
        end
        S_MEMWB: begin
          regwrite = 1'b1;  memtoreg = 1'b1;
          half = op_half;  b = op_byte;  lbu = op_ubyte;
        end
        S_MEMWR: begin
          iord = 1'b1;  memwrite = 1'b1;
          half = op_half;  b = op_byte;  lbu = op_ubyte;
        end
        S_RTYPEEX: begin
          alusrca = 1'b1;  alu_op = rtype_alu(funct);
        end
        S_RTYPEWB: begin
          regdst = 1'b1;  regwrite = 1'b1;
        end
        S_BRANCH: begin
          alusrca = 1'b1;  alu_op = ALU_SUB;  branch = 1'b1;
          pcsrc = 2'b01;  ne = (op == OP_BNE);
        end
        S_IEX: begin
          alusrca = 1'b1;  alusrcb = 2'b10;  alu_op = imm_alu(op);
          zeroimm = (op == OP_ANDI) || (op == OP_ORI);
        end
        S_IWB:  regwrite = 1'b1;
        S_JUMP: begin pcsrc = 2'b10;  pcwrite = 1'b1; end
        S_JAL: begin
          pcsrc = 2'b10;  pcwrite = 1'b1;  regwrite = 1'b1;  link = 1'b1;
        end
        S_JR:   begin pcsrc = 2'b11;  pcwrite = 1'b1; end
        default: ;
      endcase
    end
  end

  // Branches only load the PC when the zero flag matches the beq/bne sense
  assign pcen       = pcwrite | (branch & (zero ^ ne));
  assign alucontrol = ACW'(alu_op);

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: two instances (all options on / sub-word and link off,
// ACW=5). Each instruction is expanded into its expected per-cycle control trace
// from the instruction class; a monitor compares every cycle on the falling edge.
module tb_mc_controller;

  typedef struct packed {
    logic       iord, memread, memwrite, irwrite, pcen;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       zeroimm;
    logic [7:0] alu;
    logic       regdst, memtoreg, regwrite, ne, half, b, lbu, link, illegal;
  } rec_t;

  localparam int C_LOAD = 0, C_STORE = 1, C_R = 2, C_JR = 3, C_BR = 4;
  localparam int C_IMM = 5, C_J = 6, C_JAL = 7, C_ILL = 8;
  localparam logic [7:0] A_AND = 8'h00, A_OR = 8'h01, A_ADD = 8'h02;
  localparam logic [7:0] A_SUB = 8'h06, A_SLT = 8'h07, A_NOR = 8'h0C;

  logic clk = 1'b0;
  logic rst0_n, rst1_n;
  logic [5:0] op0, funct0, op1, funct1;
  logic zero0, zero1, mr0, mr1;

  logic iord0, memread0, memwrite0, irwrite0, pcen0, alusrca0, zeroimm0;
  logic regdst0, memtoreg0, regwrite0, ne0, half0, b0, lbu0, link0, illegal0;
  logic [1:0] pcsrc0, alusrcb0;
  logic [3:0] alu0;
  logic iord1, memread1, memwrite1, irwrite1, pcen1, alusrca1, zeroimm1;
  logic regdst1, memtoreg1, regwrite1, ne1, half1, b1, lbu1, link1, illegal1;
  logic [1:0] pcsrc1, alusrcb1;
  logic [4:0] alu1;

  rec_t act0, act1;
  rec_t q0[$], q1[$];
  int checks = 0;
  int errors = 0;

  logic [5:0] op_pool [16] = '{6'b000000, 6'b000010, 6'b000011, 6'b000100,
                               6'b000101, 6'b001000, 6'b001010, 6'b001100,
                               6'b001101, 6'b100000, 6'b100001, 6'b100011,
                               6'b100100, 6'b101000, 6'b101001, 6'b101011};
  logic [5:0] fn_pool [7] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                              6'b100111, 6'b101010, 6'b001000};

  always #5 clk = ~clk;

  mc_controller #(.ACW(4), .EN_SUBWORD(1), .EN_LINK(1)) dut0 (
    .clk(clk), .reset_n(rst0_n), .op(op0), .funct(funct0), .zero(zero0),
    .mem_ready(mr0), .iord(iord0), .memread(memread0), .memwrite(memwrite0),
    .irwrite(irwrite0), .pcen(pcen0), .pcsrc(pcsrc0), .alusrca(alusrca0),
    .alusrcb(alusrcb0), .zeroimm(zeroimm0), .alucontrol(alu0), .regdst(regdst0),
    .memtoreg(memtoreg0), .regwrite(regwrite0), .ne(ne0), .half(half0), .b(b0),
    .lbu(lbu0), .link(link0), .illegal(illegal0));

  mc_controller #(.ACW(5), .EN_SUBWORD(0), .EN_LINK(0)) dut1 (
    .clk(clk), .reset_n(rst1_n), .op(op1), .funct(funct1), .zero(zero1),
    .mem_ready(mr1), .iord(iord1), .memread(memread1), .memwrite(memwrite1),
    .irwrite(irwrite1), .pcen(pcen1), .pcsrc(pcsrc1), .alusrca(alusrca1),
    .alusrcb(alusrcb1), .zeroimm(zeroimm1), .alucontrol(alu1), .regdst(regdst1),
    .memtoreg(memtoreg1), .regwrite(regwrite1), .ne(ne1), .half(half1), .b(b1),
    .lbu(lbu1), .link(link1), .illegal(illegal1));

  assign act0 = {iord0, memread0, memwrite0, irwrite0, pcen0, pcsrc0, alusrca0,
                 alusrcb0, zeroimm0, 8'(alu0), regdst0, memtoreg0, regwrite0, ne0,
                 half0, b0, lbu0, link0, illegal0};
  assign act1 = {iord1, memread1, memwrite1, irwrite1, pcen1, pcsrc1, alusrca1,
                 alusrcb1, zeroimm1, 8'(alu1), regdst1, memtoreg1, regwrite1, ne1,
                 half1, b1, lbu1, link1, illegal1};

  // Instruction class as the ISA defines it, honouring the enabled options
  function automatic int classify(input logic [5:0] o, input logic [5:0] f,
                                  input bit sub, input bit lnk);
    case (o)
      6'b100011: return C_LOAD;
      6'b101011: return C_STORE;
      6'b100000, 6'b100001, 6'b100100: return sub ? C_LOAD : C_ILL;
      6'b101000, 6'b101001: return sub ? C_STORE : C_ILL;
      6'b000000: return (f == 6'b001000) ? (lnk ? C_JR : C_ILL) : C_R;
      6'b000100, 6'b000101: return C_BR;
      6'b001000, 6'b001010, 6'b001100, 6'b001101: return C_IMM;
      6'b000010: return C_J;
      6'b000011: return lnk ? C_JAL : C_ILL;
      default: return C_ILL;
    endcase
  endfunction

  function automatic logic [7:0] funct_alu(input logic [5:0] f);
    case (f)
      6'b100010: return A_SUB;
      6'b100100: return A_AND;
      6'b100101: return A_OR;
      6'b100111: return A_NOR;
      6'b101010: return A_SLT;
      default:   return A_ADD;
    endcase
  endfunction

  function automatic rec_t with_width(input rec_t r, input logic [5:0] o);
    rec_t t;
    t = r;
    t.half = (o == 6'b100001) || (o == 6'b101001);
    t.b    = (o == 6'b100000) || (o == 6'b101000) || (o == 6'b100100);
    t.lbu  = (o == 6'b100100);
    return t;
  endfunction

  task automatic check_rec(input string name, input int d, input rec_t got, input rec_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s dut%0d: got=%h want=%h", name, d, got, want);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got=%b want=%b", name, got, want);
    end
  endtask

  // Build the expected trace for one instruction, then drive it cycle by cycle.
  // limit >= 0 stops after that many cycles (used to abort mid-instruction).
  task automatic run_instr(input int d, input logic [5:0] o, input logic [5:0] f,
                           input logic z, input int fw, input int mw, input int limit);
    rec_t tr[$];
    bit   mr[$];
    rec_t r;
    int   cls, n;
    cls = classify(o, f, d == 0, d == 0);
    for (int i = 0; i <= fw; i++) begin
      r = '0; r.memread = 1'b1; r.alusrcb = 2'b01; r.alu = A_ADD;
      r.irwrite = (i == fw); r.pcen = (i == fw);
      tr.push_back(r); mr.push_back(i == fw);
    end
    r = '0; r.alusrcb = 2'b11; r.alu = A_ADD; r.illegal = (cls == C_ILL);
    tr.push_back(r); mr.push_back(1'($urandom));
    case (cls)
      C_LOAD, C_STORE: begin
        r = '0; r.alusrca = 1'b1; r.alusrcb = 2'b10; r.alu = A_ADD;
        tr.push_back(with_width(r, o)); mr.push_back(1'($urandom));
        for (int i = 0; i <= mw; i++) begin
          r = '0; r.iord = 1'b1;
          if (cls == C_LOAD) r.memread = 1'b1; else r.memwrite = 1'b1;
          tr.push_back(with_width(r, o)); mr.push_back(i == mw);
        end
        if (cls == C_LOAD) begin
          r = '0; r.regwrite = 1'b1; r.memtoreg = 1'b1;
          tr.push_back(with_width(r, o)); mr.push_back(1'($urandom));
        end
      end
      C_R: begin
        r = '0; r.alusrca = 1'b1; r.alu = funct_alu(f);
        tr.push_back(r); mr.push_back(1'($urandom));
        r = '0; r.regdst = 1'b1; r.regwrite = 1'b1;
        tr.push_back(r); mr.push_back(1'($urandom));
      end
      C_BR: begin
        r = '0; r.alusrca = 1'b1; r.alu = A_SUB; r.pcsrc = 2'b01;
        r.ne = (o == 6'b000101); r.pcen = z ^ r.ne;
        tr.push_back(r); mr.push_back(1'($urandom));
      end
      C_IMM: begin
        r = '0; r.alusrca = 1'b1; r.alusrcb = 2'b10;
        r.alu = (o == 6'b001100) ? A_AND : (o == 6'b001101) ? A_OR :
                (o == 6'b001010) ? A_SLT : A_ADD;
        r.zeroimm = (o == 6'b001100) || (o == 6'b001101);
        tr.push_back(r); mr.push_back(1'($urandom));
        r = '0; r.regwrite = 1'b1;
        tr.push_back(r); mr.push_back(1'($urandom));
      end
      C_J, C_JAL, C_JR: begin
        r = '0; r.pcen = 1'b1; r.pcsrc = (cls == C_JR) ? 2'b11 : 2'b10;
        r.regwrite = (cls == C_JAL); r.link = (cls == C_JAL);
        tr.push_back(r); mr.push_back(1'($urandom));
      end
      default: ;
    endcase
    n = (limit < 0) ? tr.size() : limit;
    $display("dut%0d op=%b funct=%b zero=%b class=%0d cycles=%0d", d, o, f, z, cls, n);
    for (int i = 0; i < n; i++) begin
      if (d == 0) begin
        op0 = o; funct0 = f; zero0 = z; mr0 = mr[i]; q0.push_back(tr[i]);
      end else begin
        op1 = o; funct1 = f; zero1 = z; mr1 = mr[i]; q1.push_back(tr[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic random_run(input int d, input int count);
    logic [5:0] o, f;
    int sel;
    for (int k = 0; k < count; k++) begin
      sel = $urandom_range(0, 19);
      o = (sel < 16) ? op_pool[sel] : 6'($urandom);
      sel = $urandom_range(0, 9);
      f = (sel < 7) ? fn_pool[sel] : 6'($urandom);
      run_instr(d, o, f, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2), -1);
    end
  endtask

  // Monitor: every falling edge, compare each DUT against its oldest expected cycle
  always @(negedge clk) begin
    if (q0.size() > 0) check_rec("ctl", 0, act0, q0.pop_front());
    if (q1.size() > 0) check_rec("ctl", 1, act1, q1.pop_front());
  end

  initial begin
    rst0_n = 1'b1; rst1_n = 1'b1;
    op0 = '0; funct0 = '0; zero0 = 1'b0; mr0 = 1'b1;
    op1 = '0; funct1 = '0; zero1 = 1'b0; mr1 = 1'b1;
    #1 rst0_n = 1'b0; rst1_n = 1'b0;
    #1;
    check_rec("reset_outputs", 0, act0, '0);
    check_rec("reset_outputs", 1, act1, '0);
    @(posedge clk); #2;
    check_rec("reset_held", 0, act0, '0);
    check_rec("reset_held", 1, act1, '0);
    @(negedge clk); #2;
    rst0_n = 1'b1; rst1_n = 1'b1;
    @(posedge clk); #1;
    fork
      begin
        run_instr(0, 6'b100011, 6'b000000, 1'b0, 3, 2, -1);  // lw with waits
        run_instr(0, 6'b000000, 6'b100000, 1'b0, 0, 0, -1);  // add
        run_instr(0, 6'b000000, 6'b100111, 1'b0, 0, 0, -1);  // nor
        run_instr(0, 6'b000101, 6'b000000, 1'b0, 0, 0, -1);  // bne taken
        run_instr(0, 6'b000101, 6'b000000, 1'b1, 0, 0, -1);  // bne not taken
        run_instr(0, 6'b000100, 6'b000000, 1'b1, 0, 0, -1);  // beq taken
        run_instr(0, 6'b000011, 6'b000000, 1'b0, 1, 0, -1);  // jal
        run_instr(0, 6'b100100, 6'b000000, 1'b0, 0, 1, -1);  // lbu
        random_run(0, 120);
        // Abort a store in MEMWR with reset, then confirm a clean restart
        run_instr(0, 6'b101011, 6'b000000, 1'b0, 0, 5, 4);
        check_bit("memwrite_before_reset", memwrite0, 1'b1);
        #2 rst0_n = 1'b0;
        #1;
        check_bit("memwrite_async_drop", memwrite0, 1'b0);
        check_rec("reset_abort_outputs", 0, act0, '0);
        @(posedge clk); #1;
        check_rec("reset_abort_held", 0, act0, '0);
        @(negedge clk); #2 rst0_n = 1'b1;
        @(posedge clk); #1;
        run_instr(0, 6'b100011, 6'b000000, 1'b0, 1, 1, -1);
      end
      begin
        run_instr(1, 6'b000011, 6'b000000, 1'b0, 0, 0, -1);  // jal disabled
        run_instr(1, 6'b100100, 6'b000000, 1'b0, 1, 0, -1);  // lbu disabled
        run_instr(1, 6'b000000, 6'b001000, 1'b0, 0, 0, -1);  // jr disabled
        run_instr(1, 6'b100011, 6'b000000, 1'b0, 2, 1, -1);  // lw
        random_run(1, 120);
      end
    join
    repeat (3) @(posedge clk);
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain: pending q0=%0d q1=%0d required 0", q0.size(), q1.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
